// File: rtl/hazard_ctrl_pkg.sv
// Shared types and helpers for the decode-stage hazard controller.
//   hz_state_e      : encoding of the controller FSM (2 bits, 3 is illegal)
//   FLUSH_CNT_W     : width of the post-redirect flush counter
//   load_use_hazard : detects a RAW dependence on a load still in EX
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_MEM_WAIT = 2'd1,
        HZ_FLUSH    = 2'd2
    } hz_state_e;

    localparam int unsigned FLUSH_CNT_W = 3;

    // A load in EX cannot forward in time for the instruction in ID.
    // Writes to x0 are discarded, so they never create a dependence.
    function automatic logic load_use_hazard(
        input logic       id_valid,
        input logic       ex_valid,
        input logic       ex_is_load,
        input logic [4:0] rs1_idx,
        input logic [4:0] rs2_idx,
        input logic [4:0] rd_idx
    );
        return id_valid & ex_valid & ex_is_load & (rd_idx != 5'd0) &
               ((rs1_idx == rd_idx) | (rs2_idx == rd_idx));
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline (master) and the hazard controller (slave).
//   Decode-side inputs : id_valid_i, id_opcode_i, id_rs1_idx_i, id_rs2_idx_i
//   EX/MEM-side inputs : ex_valid_i, ex_is_load_i, ex_rd_idx_i, ex_redirect_i, mem_busy_i
//   Control outputs    : pc/ifid/idex/exmem stall and flush strobes
//   Debug / statistics : state_o, lu_stall_cnt_o, mem_wait_cnt_o, flush_cnt_o
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    import hazard_ctrl_pkg::*;

    logic             id_valid_i;
    logic [6:0]       id_opcode_i;
    logic [4:0]       id_rs1_idx_i;
    logic [4:0]       id_rs2_idx_i;
    logic             ex_valid_i;
    logic             ex_is_load_i;
    logic [4:0]       ex_rd_idx_i;
    logic             ex_redirect_i;
    logic             mem_busy_i;
    logic             pc_stall_o;
    logic             ifid_stall_o;
    logic             ifid_flush_o;
    logic             idex_stall_o;
    logic             idex_flush_o;
    logic             exmem_stall_o;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] lu_stall_cnt_o;
    logic [CNT_W-1:0] mem_wait_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    modport master (
        output id_valid_i, id_opcode_i, id_rs1_idx_i, id_rs2_idx_i,
        output ex_valid_i, ex_is_load_i, ex_rd_idx_i, ex_redirect_i, mem_busy_i,
        input  pc_stall_o, ifid_stall_o, ifid_flush_o, idex_stall_o,
        input  idex_flush_o, exmem_stall_o, state_o,
        input  lu_stall_cnt_o, mem_wait_cnt_o, flush_cnt_o
    );

    modport slave (
        input  id_valid_i, id_opcode_i, id_rs1_idx_i, id_rs2_idx_i,
        input  ex_valid_i, ex_is_load_i, ex_rd_idx_i, ex_redirect_i, mem_busy_i,
        output pc_stall_o, ifid_stall_o, ifid_flush_o, idex_stall_o,
        output idex_flush_o, exmem_stall_o, state_o,
        output lu_stall_cnt_o, mem_wait_cnt_o, flush_cnt_o
    );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for hazard statistics.
//   clk_i, rst_ni : clock, async active-low reset
//   clr_i         : synchronous clear
//   inc_i         : count one event this cycle
//   cnt_o         : current count, sticks at all-ones
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
    localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

    // Count register: clear wins over increment, holds at the maximum.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_o <= {W{1'b0}};
        end else if (clr_i) begin
            cnt_o <= {W{1'b0}};
        end else if (inc_i && (cnt_o != CNT_MAX)) begin
            cnt_o <= cnt_o + CNT_ONE;
        end else begin
            cnt_o <= cnt_o;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage hazard controller for the 5-stage RV32I pipeline.
// Sequences IF/ID and ID/EX around load-use hazards, data-memory waits and
// control redirects, and keeps saturating statistics counters.
//   clk_i, rst_ni : clock, async active-low reset
//   hz (slave)    : decode/EX/MEM status in, stall/flush controls and stats out
// Control outputs are combinational from state and inputs (same-cycle
// response) and are forced low while rst_ni is asserted.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int          CNT_W        = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    hazard_ctrl_if.slave  hz
);

    localparam logic [1:0] ST_RUN      = HZ_RUN;
    localparam logic [1:0] ST_MEM_WAIT = HZ_MEM_WAIT;
    localparam logic [1:0] ST_FLUSH    = HZ_FLUSH;

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_RELOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
    localparam logic                   GO_FLUSH     = (FLUSH_CYCLES > 1) ? 1'b1 : 1'b0;
    localparam logic [1:0]             ST_AFTER_RDR = GO_FLUSH ? ST_FLUSH : ST_RUN;

    logic [1:0]             state_r;
    logic [1:0]             state_nxt_s;
    logic [FLUSH_CNT_W-1:0] fcnt_r;
    logic [FLUSH_CNT_W-1:0] fcnt_nxt_s;
    logic                   pend_r;
    logic                   pend_nxt_s;

    logic lu_hz_s;
    logic stall_all_s;
    logic do_redirect_s;
    logic do_lu_s;
    logic flush_step_s;
    logic mw_inc_s;

    logic unused_opcode_s;
    assign unused_opcode_s = ^hz.id_opcode_i;

    assign lu_hz_s = load_use_hazard(hz.id_valid_i, hz.ex_valid_i, hz.ex_is_load_i,
                                     hz.id_rs1_idx_i, hz.id_rs2_idx_i, hz.ex_rd_idx_i);

    // Next-state and action decode; memory wait beats redirect beats load-use.
    always_comb begin
        state_nxt_s   = state_r;
        fcnt_nxt_s    = fcnt_r;
        pend_nxt_s    = pend_r;
        stall_all_s   = 1'b0;
        do_redirect_s = 1'b0;
        do_lu_s       = 1'b0;
        flush_step_s  = 1'b0;
        mw_inc_s      = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (hz.mem_busy_i) begin
                    stall_all_s = 1'b1;
                    mw_inc_s    = 1'b1;
                    pend_nxt_s  = pend_r | hz.ex_redirect_i;
                    state_nxt_s = ST_MEM_WAIT;
                end else if (hz.ex_redirect_i) begin
                    // Younger instruction in ID is squashed, so lu_hz is moot.
                    do_redirect_s = 1'b1;
                    fcnt_nxt_s    = FLUSH_RELOAD;
                    pend_nxt_s    = 1'b0;
                    state_nxt_s   = ST_AFTER_RDR;
                end else if (lu_hz_s) begin
                    do_lu_s = 1'b1;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                if (hz.mem_busy_i) begin
                    stall_all_s = 1'b1;
                    mw_inc_s    = 1'b1;
                    pend_nxt_s  = pend_r | hz.ex_redirect_i;
                end else if (pend_r || hz.ex_redirect_i) begin
                    do_redirect_s = 1'b1;
                    fcnt_nxt_s    = FLUSH_RELOAD;
                    pend_nxt_s    = 1'b0;
                    state_nxt_s   = ST_AFTER_RDR;
                end else begin
                    do_lu_s     = lu_hz_s;
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (hz.mem_busy_i) begin
                    // Counter frozen so no flush slot is lost while stalled.
                    stall_all_s = 1'b1;
                    pend_nxt_s  = pend_r | hz.ex_redirect_i;
                end else if (pend_r || hz.ex_redirect_i) begin
                    do_redirect_s = 1'b1;
                    fcnt_nxt_s    = FLUSH_RELOAD;
                    pend_nxt_s    = 1'b0;
                    state_nxt_s   = ST_AFTER_RDR;
                end else begin
                    flush_step_s = 1'b1;
                    if (fcnt_r <= FLUSH_CNT_W'(1)) begin
                        fcnt_nxt_s  = {FLUSH_CNT_W{1'b0}};
                        state_nxt_s = ST_RUN;
                    end else begin
                        fcnt_nxt_s  = fcnt_r - FLUSH_CNT_W'(1);
                    end
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
                fcnt_nxt_s  = {FLUSH_CNT_W{1'b0}};
                pend_nxt_s  = 1'b0;
            end
        endcase
    end

    // FSM state, flush counter and deferred-redirect flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_RUN;
            fcnt_r  <= {FLUSH_CNT_W{1'b0}};
            pend_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            fcnt_r  <= fcnt_nxt_s;
            pend_r  <= pend_nxt_s;
        end
    end

    // Gating with rst_ni makes a mid-operation reset drop every control at once.
    assign hz.pc_stall_o    = rst_ni & (stall_all_s | do_lu_s);
    assign hz.ifid_stall_o  = rst_ni & (stall_all_s | do_lu_s);
    assign hz.ifid_flush_o  = rst_ni & (do_redirect_s | flush_step_s);
    assign hz.idex_stall_o  = rst_ni & stall_all_s;
    assign hz.idex_flush_o  = rst_ni & (do_redirect_s | do_lu_s);
    assign hz.exmem_stall_o = rst_ni & stall_all_s;
    assign hz.state_o       = state_r;

    sat_counter #(.W(CNT_W)) u_lu_cnt (
        .clk_i (clk_i), .rst_ni (rst_ni), .clr_i (1'b0),
        .inc_i (do_lu_s), .cnt_o (hz.lu_stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_mw_cnt (
        .clk_i (clk_i), .rst_ni (rst_ni), .clr_i (1'b0),
        .inc_i (mw_inc_s), .cnt_o (hz.mem_wait_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_fl_cnt (
        .clk_i (clk_i), .rst_ni (rst_ni), .clr_i (1'b0),
        .inc_i (do_redirect_s), .cnt_o (hz.flush_cnt_o)
    );

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline controller for the 5-stage RV32I core. It sequences the IF/ID and ID/EX registers around the decode stage.
- Consumes the register indices and opcode produced by decode, plus EX/MEM status. Produces stall, flush and bubble controls.
- Resolves three hazard classes: load-use, data-memory wait and control redirect.
- Keeps hazard statistics counters.
- The EX/MEM/WB forwarding network covers all RAW cases except a load in EX.

Parameters:
- FLUSH_CYCLES, 1: cycles IF/ID is flushed after a redirect, matching instruction-memory latency. Range 1..7.
- CNT_W, 32: width of the statistics counters.

Ports:
- clk_i  in  1  core clock
- rst_ni  in  1  reset
- id_valid_i  in  1  IF/ID holds a valid instruction
- id_opcode_i  in  7  decoded opcode
- id_rs1_idx_i  in  5  decoded rs1 index; already zeroed by decode when unused
- id_rs2_idx_i  in  5  decoded rs2 index; already zeroed by decode when unused
- ex_valid_i  in  1  ID/EX holds a valid instruction
- ex_is_load_i  in  1  instruction in EX is a LOAD
- ex_rd_idx_i  in  5  rd of the instruction in EX
- ex_redirect_i  in  1  taken branch, JAL or JALR resolved in EX
- mem_busy_i  in  1  data memory not ready this cycle
- pc_stall_o  out  1  hold the PC
- ifid_stall_o  out  1  hold IF/ID
- ifid_flush_o  out  1  clear IF/ID valid
- idex_stall_o  out  1  hold ID/EX
- idex_flush_o  out  1  load a bubble into ID/EX
- exmem_stall_o  out  1  hold EX/MEM and MEM/WB
- state_o  out  2  FSM state, for debug
- lu_stall_cnt_o  out  CNT_W  load-use stall cycles
- mem_wait_cnt_o  out  CNT_W  memory-wait cycles
- flush_cnt_o  out  CNT_W  redirects taken

Behaviour:

Interface and reset:
- clk_i is the single clock. rst_ni is the reset: asynchronous assert, active-low.
- During reset and on release: state=RUN (2'd0), flush counter=0, pending_redirect=0, all statistics counters=0, all control outputs=0.
- Reset asserted mid-stall or mid-flush aborts the operation immediately, with no residual stall or flush.

Load-use hazard (combinational):
- lu_hz = id_valid_i & ex_valid_i & ex_is_load_i & (ex_rd_idx_i != 0) & ((id_rs1_idx_i == ex_rd_idx_i) | (id_rs2_idx_i == ex_rd_idx_i)).
- rd = x0 never hazards.

FSM states:
- RUN=0, MEM_WAIT=1, FLUSH=2. Value 3 is illegal and recovers to RUN.
- All control outputs are combinational from state and inputs. The same-cycle response is required.

Priority in RUN, highest first:
1. mem_busy_i:
   - assert pc_stall, ifid_stall, idex_stall, exmem_stall.
   - If ex_redirect_i is also high, set pending_redirect.
   - Next state: MEM_WAIT.
2. ex_redirect_i:
   - assert ifid_flush and idex_flush.
   - Increment flush_cnt_o.
   - If FLUSH_CYCLES > 1: load counter with FLUSH_CYCLES-1 and go to FLUSH. Otherwise stay in RUN.
   - A concurrent lu_hz is ignored, because the younger instruction is squashed.
3. lu_hz:
   - assert pc_stall, ifid_stall, idex_flush for exactly this cycle.
   - Increment lu_stall_cnt_o. Stay in RUN.
   - Next cycle the load has left EX, so lu_hz self-clears.

MEM_WAIT:
- All four stalls stay asserted while mem_busy_i=1. mem_wait_cnt_o increments every cycle in this state, including the entry cycle from RUN.
- ex_redirect_i seen during the wait sets pending_redirect.
- On the first cycle with mem_busy_i=0:
  - if pending_redirect or ex_redirect_i: act as a RUN redirect (flush, count, go to FLUSH or RUN), then clear pending_redirect.
  - else: evaluate lu_hz as in RUN and go to RUN.

FLUSH:
- ifid_flush asserted, pc not stalled. Decrement the counter and go to RUN when it reaches 0.
- mem_busy_i in FLUSH: assert the stalls and freeze the counter. The state stays FLUSH.
- A new ex_redirect_i in FLUSH reloads the counter and increments flush_cnt_o.

Counters:
- Saturate at all-ones; they do not wrap.

Decomposition:
- Add to the CPU_profile package: `hz_state_e` {HZ_RUN, HZ_MEM_WAIT, HZ_FLUSH} as a 2-bit enum.
- Keep the opcode constants in the existing decode package.
- One sub-module, `sat_counter` (parameterised width, inc, clear), instantiated three times for the statistics.

Test Plan:
- LW x5 in EX, ADD x6,x5,x1 in ID → one cycle of pc_stall=ifid_stall=idex_flush=1. Cycle after: all low. lu_stall_cnt_o=1.
- LW x0 in EX, ID reads x0 → no stall. Load x5 with ID reading only x7 → no stall.
- mem_busy_i high 3 cycles from RUN → exmem_stall, idex_stall, pc_stall, ifid_stall each high exactly 3 cycles. state_o goes 1 then 0. mem_wait_cnt_o=3.
- ex_redirect_i pulse with FLUSH_CYCLES=3 → ifid_flush high 3 consecutive cycles, idex_flush high the first cycle only. flush_cnt_o=1. state_o sequence 0,2,2,0.
- ex_redirect_i plus mem_busy_i together for 2 cycles → stalls for 2 cycles, then flush on the release cycle. flush_cnt_o=1.
- rst_ni dropped during FLUSH counter=2 → all outputs 0 asynchronously. After release state_o=0 and counters=0.
